// File: rtl/occ_rx_link_sync.sv
// occ_rx_link_sync: GTPE2 RX comma detect, link sync FSM, payload qualification and error stats.
// Define OCC_RX_LINK_SYNC_STATS_EN to build the code-error/realign statistics counters.
module occ_rx_link_sync #(
    parameter int unsigned g_SYNC_COMMAS   = 4,
    parameter int unsigned g_ERR_THRESH    = 8,
    parameter int unsigned g_GOOD_WORDS    = 64,
    parameter int unsigned g_COMMA_TIMEOUT = 256
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [15:0] rxdata_i,
    input  logic [1:0]  rxcharisk_i,
    input  logic [1:0]  rxdisperr_i,
    input  logic [1:0]  rxnotintable_i,
    input  logic        rxbyterealign_i,
    output logic        rxencommaalign_o,
    output logic        link_up_o,
    output logic [15:0] data_o,
    output logic        data_valid_o,
    output logic        comma_o,
    output logic        code_err_o,
    input  logic        clr_cnt_i,
    output logic [15:0] code_err_cnt_o,
    output logic [15:0] realign_cnt_o
);
    localparam int SW = $clog2(g_SYNC_COMMAS + 1);
    localparam int BW = $clog2(g_ERR_THRESH + 1);
    localparam int GW = $clog2(g_GOOD_WORDS + 1);
    localparam int TW = $clog2(g_COMMA_TIMEOUT + 1);
    localparam logic [SW-1:0] SYNC_N = SW'(g_SYNC_COMMAS);
    localparam logic [BW-1:0] ERR_N  = BW'(g_ERR_THRESH);
    localparam logic [GW-1:0] GOOD_N = GW'(g_GOOD_WORDS);
    localparam logic [TW-1:0] TMO_N  = TW'(g_COMMA_TIMEOUT);

    typedef enum logic {HUNT, SYNC} state_t;
    state_t state, state_nx;
    logic [SW-1:0] sync_cnt, sync_nx;
    logic [BW-1:0] bucket, bucket_nx;
    logic [GW-1:0] good, good_nx, good_inc;
    logic [TW-1:0] tmo, tmo_nx;
    logic [15:0] d_q;
    logic comma_in, err_in, comma_q, err_q, realign_q;

    // A K flag is legal only on the comma's upper byte; anything else is a code error.
    assign comma_in = (rxcharisk_i == 2'b10) && (rxdata_i[15:8] == 8'hBC);
    assign err_in   = (|rxdisperr_i) | (|rxnotintable_i) | ((|rxcharisk_i) & ~comma_in);
    assign good_inc = good + 1'b1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            d_q       <= '0;
            comma_q   <= 1'b0;
            err_q     <= 1'b0;
            realign_q <= 1'b0;
        end else begin
            d_q       <= rxdata_i;
            comma_q   <= comma_in;
            err_q     <= err_in;
            realign_q <= rxbyterealign_i;
        end
    end

    always_comb begin
        state_nx  = state;
        sync_nx   = sync_cnt;
        bucket_nx = bucket;
        good_nx   = good;
        tmo_nx    = tmo;
        if (state == HUNT) begin
            sync_nx = err_q ? '0 : comma_q ? sync_cnt + 1'b1 : sync_cnt;
            if (sync_nx == SYNC_N) begin
                state_nx  = SYNC;
                sync_nx   = '0;
                bucket_nx = '0;
                good_nx   = '0;
                tmo_nx    = '0;
            end
        end else begin
            tmo_nx = comma_q ? '0 : tmo + 1'b1;
            if (err_q) begin
                bucket_nx = bucket + 1'b1;
                good_nx   = '0;
            end else if (good_inc == GOOD_N) begin
                bucket_nx = (bucket == '0) ? '0 : bucket - 1'b1;
                good_nx   = '0;
            end else begin
                good_nx = good_inc;
            end
            if (realign_q || bucket_nx == ERR_N || tmo_nx == TMO_N) begin
                state_nx = HUNT;
                sync_nx  = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= HUNT;
            sync_cnt     <= '0;
            bucket       <= '0;
            good         <= '0;
            tmo          <= '0;
            data_o       <= '0;
            data_valid_o <= 1'b0;
            comma_o      <= 1'b0;
            code_err_o   <= 1'b0;
        end else begin
            state        <= state_nx;
            sync_cnt     <= sync_nx;
            bucket       <= bucket_nx;
            good         <= good_nx;
            tmo          <= tmo_nx;
            data_o       <= d_q;
            data_valid_o <= (state_nx == SYNC) && !comma_q && !err_q;
            comma_o      <= comma_q;
            code_err_o   <= err_q;
        end
    end

    assign link_up_o        = (state == SYNC);
    assign rxencommaalign_o = (state == HUNT);

`ifdef OCC_RX_LINK_SYNC_STATS_EN
    logic [15:0] err_cnt, re_cnt;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_cnt <= '0;
            re_cnt  <= '0;
        end else begin
            err_cnt <= clr_cnt_i ? '0 : (err_q && ~&err_cnt) ? err_cnt + 1'b1 : err_cnt;
            re_cnt  <= clr_cnt_i ? '0 : (realign_q && ~&re_cnt) ? re_cnt + 1'b1 : re_cnt;
        end
    end
    assign code_err_cnt_o = err_cnt;
    assign realign_cnt_o  = re_cnt;
`else
    logic unused_clr;
    assign unused_clr     = clr_cnt_i;
    assign code_err_cnt_o = '0;
    assign realign_cnt_o  = '0;
`endif
endmodule

// File: tb/tb_occ_rx_link_sync.sv
// tb_occ_rx_link_sync: directed bench for occ_rx_link_sync; outputs lag inputs by two edges.
module tb_occ_rx_link_sync;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [15:0] rxdata = '0;
    logic [1:0]  rxk = '0, rxde = '0, rxnit = '0;
    logic        realign = 1'b0, clr = 1'b0;
    logic        enc, link_up, data_valid, comma, code_err;
    logic [15:0] data, err_cnt, re_cnt;
    int errors = 0, checks = 0, w = 0, nv = 0;
`ifdef OCC_RX_LINK_SYNC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    occ_rx_link_sync dut (
        .clk_i(clk), .rst_n_i(rst_n), .rxdata_i(rxdata), .rxcharisk_i(rxk),
        .rxdisperr_i(rxde), .rxnotintable_i(rxnit), .rxbyterealign_i(realign),
        .rxencommaalign_o(enc), .link_up_o(link_up), .data_o(data),
        .data_valid_o(data_valid), .comma_o(comma), .code_err_o(code_err),
        .clr_cnt_i(clr), .code_err_cnt_o(err_cnt), .realign_cnt_o(re_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ex(input int v);
        return STATS ? 32'(v) : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic word(input logic [15:0] d, input logic [1:0] k, input logic [1:0] de, input logic re);
        rxdata = d; rxk = k; rxde = de; realign = re;
        @(posedge clk); #1;
    endtask

    // Pattern stream: comma every 32 words when c is set, otherwise the word index.
    task automatic strm(input bit c, input logic [1:0] de);
        if (c && w % 32 == 0) word(16'hBC95, 2'b10, de, 1'b0);
        else word(w[15:0], 2'b00, de, 1'b0);
        w++;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_enc", enc, 1); chk("rst_link", link_up, 0); chk("rst_valid", data_valid, 0);
        chk("rst_data", data, 0); chk("rst_errcnt", err_cnt, 0); chk("rst_recnt", re_cnt, 0);
        rst_n = 1'b1;
        repeat (3) word(16'h0000, 2'b00, 2'b00, 1'b0);
        chk("idle_enc", enc, 1); chk("idle_link", link_up, 0); chk("idle_valid", data_valid, 0);

        // clean stream: sync on the 4th comma (word 96)
        w = 0;
        repeat (97) strm(1, 2'b00);
        chk("presync_link", link_up, 0);
        strm(1, 2'b00);
        chk("sync_link", link_up, 1); chk("sync_comma", comma, 1); chk("sync_enc", enc, 0);
        repeat (31) strm(1, 2'b00);
        for (int i = 0; i < 32; i++) begin
            strm(1, 2'b00);
            if (i == 0) chk("period_comma", comma, 1);
            if (data_valid) begin
                nv++;
                chk("period_data", data, w - 2);
            end
        end
        chk("period_nvalid", nv, 31);

        // 8 spaced disparity errors overflow the bucket
        while (w < 170) strm(1, 2'b00);
        for (int e = 0; e < 8; e++) begin
            strm(1, 2'b01);
            if (e < 7) repeat (9) strm(1, 2'b00);
        end
        chk("err7_link", link_up, 1);
        strm(1, 2'b00);
        chk("err8_link", link_up, 0); chk("err8_enc", enc, 1); chk("err8_flag", code_err, 1);
        chk("err8_cnt", err_cnt, ex(8)); chk("err8_recnt", re_cnt, 0);

        // comma timeout
        rst_n = 1'b0; #10; rst_n = 1'b1;
        w = 0;
        repeat (98) strm(1, 2'b00);
        chk("tmo_sync", link_up, 1);
        while (w < 353) strm(0, 2'b00);
        chk("tmo_255", link_up, 1);
        strm(0, 2'b00);
        chk("tmo_256", link_up, 0);
        repeat (3) word(16'hBC95, 2'b10, 2'b00, 1'b0);
        word(16'hBCFF, 2'b10, 2'b00, 1'b0);
        chk("resync3_link", link_up, 0);
        word(16'h1234, 2'b00, 2'b00, 1'b0);
        chk("resync4_link", link_up, 1); chk("resync4_comma", comma, 1);

        // byte realign and clear-vs-increment priority
        word(16'h0001, 2'b00, 2'b00, 1'b1);
        chk("pre_realign_link", link_up, 1); chk("pre_realign_valid", data_valid, 1);
        chk("pre_realign_data", data, 16'h1234);
        word(16'h0002, 2'b00, 2'b00, 1'b0);
        chk("realign_link", link_up, 0); chk("realign_enc", enc, 1); chk("realign_cnt", re_cnt, ex(1));
        word(16'h0003, 2'b01, 2'b00, 1'b0);
        clr = 1'b1;
        word(16'h0004, 2'b00, 2'b00, 1'b0);
        clr = 1'b0;
        chk("clr_flag", code_err, 1); chk("clr_errcnt", err_cnt, 0); chk("clr_recnt", re_cnt, 0);

        // HUNT: code error clears the comma count
        repeat (3) word(16'hBC95, 2'b10, 2'b00, 1'b0);
        rxnit = 2'b10;
        word(16'h0005, 2'b00, 2'b00, 1'b0);
        rxnit = 2'b00;
        repeat (3) word(16'hBC95, 2'b10, 2'b00, 1'b0);
        chk("hunt_nit_flag", code_err, 0);
        word(16'h0006, 2'b00, 2'b00, 1'b0);
        chk("hunt_clr_link", link_up, 0);
        word(16'hBC95, 2'b10, 2'b00, 1'b0);
        word(16'h0007, 2'b00, 2'b00, 1'b0);
        chk("hunt_sync_link", link_up, 1);

        // asynchronous reset mid-SYNC
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_enc", enc, 1); chk("arst_link", link_up, 0); chk("arst_data", data, 0);
        chk("arst_comma", comma, 0); chk("arst_valid", data_valid, 0); chk("arst_err", code_err, 0);
        chk("arst_errcnt", err_cnt, 0); chk("arst_recnt", re_cnt, 0);
        #10 rst_n = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
